// File: rtl/csr_req_seq.sv
// Zicsr request sequencer: decodes one CSR instruction, issues a single bus
// request, waits for the response or a timeout, and hands the result back.
module csr_req_seq #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [4:0]            req_rd_idx,
    input  logic [4:0]            req_rs1_idx,
    input  logic [REG_WIDTH-1:0]  req_rs1_val,
    input  logic [ADDR_WIDTH-1:0] req_csr_addr,
    output logic [1:0]            csr_op,
    output logic [2:0]            csr_funct3,
    output logic [4:0]            csr_imm,
    output logic [REG_WIDTH-1:0]  rs1_val,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic                  csr_valid,
    output logic                  csr_rrsp,
    input  logic [ADDR_WIDTH-1:0] csr_rdata,
    input  logic                  csr_rvalid,
    input  logic [2:0]            csr_reg_rsp,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [4:0]            wb_rd_idx,
    output logic                  wb_we,
    output logic [REG_WIDTH-1:0]  wb_data,
    output logic [2:0]            wb_rsp
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] RSP_ILLEGAL = 3'b110;
    localparam logic [2:0] RSP_TIMEOUT = 3'b111;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [4:0]       rd_q;
    logic             read_q;

    logic                 is_rw;
    logic                 dec_read;
    logic                 dec_write;
    logic                 dec_illegal;
    logic                 in_bus_phase;
    logic [REG_WIDTH-1:0] rdata_ext;
    logic [REG_WIDTH-1:0] fin_data;
    logic [2:0]           fin_rsp;

    assign is_rw       = (req_funct3[1:0] == 2'b01);
    assign dec_read    = is_rw ? (req_rd_idx != 5'd0) : 1'b1;
    assign dec_write   = is_rw ? 1'b1 : (req_rs1_idx != 5'd0);
    assign dec_illegal = (req_funct3[1:0] == 2'b00);

    assign in_bus_phase = (state == ISSUE) || (state == WAIT);
    assign csr_rrsp     = csr_rvalid && in_bus_phase;

    generate
        if (REG_WIDTH <= ADDR_WIDTH) begin : g_trunc
            assign rdata_ext = csr_rdata[REG_WIDTH-1:0];
        end else begin : g_zext
            assign rdata_ext = {{(REG_WIDTH-ADDR_WIDTH){1'b0}}, csr_rdata};
        end
    endgenerate

    // A response arriving in the last counted cycle beats the timeout.
    assign fin_data = csr_rvalid ? rdata_ext : '0;
    assign fin_rsp  = csr_rvalid ? csr_reg_rsp : RSP_TIMEOUT;

    // NOTE: every register here uses <= so all state updates see the
    // pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and covers every register; there is no
        // storage array, so nothing is left for the datapath to overwrite later.
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            rd_q       <= '0;
            read_q     <= 1'b0;
            req_ready  <= 1'b0;
            csr_op     <= '0;
            csr_funct3 <= '0;
            csr_imm    <= '0;
            rs1_val    <= '0;
            csr_addr   <= '0;
            csr_valid  <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd_idx  <= '0;
            wb_we      <= 1'b0;
            wb_data    <= '0;
            wb_rsp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rd_q      <= req_rd_idx;
                        read_q    <= dec_read;
                        tmo_cnt   <= '0;
                        if (dec_illegal) begin
                            state     <= RESP;
                            wb_valid  <= 1'b1;
                            wb_rd_idx <= req_rd_idx;
                            wb_we     <= 1'b0;
                            wb_data   <= '0;
                            wb_rsp    <= RSP_ILLEGAL;
                        end else begin
                            state      <= ISSUE;
                            csr_valid  <= 1'b1;
                            csr_op     <= {dec_read, dec_write};
                            csr_funct3 <= req_funct3;
                            csr_imm    <= req_rs1_idx;
                            rs1_val    <= req_rs1_val;
                            csr_addr   <= req_csr_addr;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                ISSUE, WAIT: begin
                    csr_valid <= 1'b0;
                    if (csr_rvalid || (tmo_cnt == CNT_LAST)) begin
                        state      <= RESP;
                        tmo_cnt    <= '0;
                        wb_valid   <= 1'b1;
                        wb_rd_idx  <= rd_q;
                        wb_data    <= fin_data;
                        wb_rsp     <= fin_rsp;
                        wb_we      <= read_q && !fin_rsp[2] && (rd_q != 5'd0);
                        csr_op     <= '0;
                        csr_funct3 <= '0;
                        csr_imm    <= '0;
                        rs1_val    <= '0;
                        csr_addr   <= '0;
                    end else begin
                        state   <= WAIT;
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (wb_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        wb_valid  <= 1'b0;
                        wb_rd_idx <= '0;
                        wb_we     <= 1'b0;
                        wb_data   <= '0;
                        wb_rsp    <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/csr_req_seq.md
Name: csr_req_seq

Overview:
- Sequencer directly upstream of the CSR address-decode bus (PMP/AIA mux).
- Accepts one decoded Zicsr instruction at a time from the execute stage.
- Derives the read/write op pair, drives the single-request CSR bus, and waits for the response with a timeout, because unmapped addresses never respond.
- Returns rd writeback data or an exception code to the pipeline through a valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, width of CSR address and CSR read data
REG_WIDTH, 32, width of rs1 value and writeback data
TIMEOUT_CYCLES, 16, cycles allowed from csr_valid to csr_rvalid before a timeout exception (must be ≥2)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_valid  input  1  CSR instruction valid
req_ready  output  1  sequencer can accept a request
req_funct3  input  3  Zicsr funct3
req_rd_idx  input  5  destination register index
req_rs1_idx  input  5  rs1 index; also used as uimm for the *I forms
req_rs1_val  input  REG_WIDTH  rs1 value
req_csr_addr  input  ADDR_WIDTH  CSR address, zero-extended 12-bit
csr_op  output  2  [1]=read, [0]=write
csr_funct3  output  3  registered funct3
csr_imm  output  5  registered uimm
rs1_val  output  REG_WIDTH  registered rs1 value
csr_addr  output  ADDR_WIDTH  registered address
csr_valid  output  1  request strobe, one-cycle pulse
csr_rrsp  output  1  response consumed
csr_rdata  input  ADDR_WIDTH  CSR read data
csr_rvalid  input  1  response valid
csr_reg_rsp  input  3  bit2 = exception, [1:0] = cause
wb_valid  output  1  result valid
wb_ready  input  1  pipeline accepts result
wb_rd_idx  output  5  destination index
wb_we  output  1  write rd
wb_data  output  REG_WIDTH  old CSR value
wb_rsp  output  3  bit2 = exception, [1:0] = cause

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- Reset values: all outputs 0, timeout counter 0. Reset mid-operation abandons the transaction, sends no csr_rrsp, and returns to IDLE next cycle.
- req_ready is 1 only in IDLE. On accept (req_valid & req_ready), register all request fields.
- Op decode at accept:
  - read = (funct3[1:0]==01) ? (rd_idx≠0) : 1
  - write = (funct3[1:0]==01) ? 1 : (rs1_idx≠0)
  - csr_imm = rs1_idx
  - funct3 000 or 100 is illegal: go to RESP with wb_rsp=3'b110, wb_we=0, no bus activity.
  - read=0 and write=0 cannot occur for legal funct3.
- Legal request: IDLE→ISSUE. csr_valid=1 for exactly this one cycle.
- csr_addr, csr_op, csr_funct3, csr_imm and rs1_val are held stable from ISSUE through the end of WAIT, then cleared to 0 in RESP/IDLE.
- Response acceptance:
  - csr_rvalid is sampled in ISSUE and WAIT.
  - csr_rrsp = csr_rvalid & (state ISSUE or WAIT), combinational.
  - On acceptance, capture csr_rdata into wb_data (truncated/zero-extended to REG_WIDTH) and csr_reg_rsp into wb_rsp, then go to RESP.
  - Otherwise ISSUE→WAIT.
- Timeout:
  - The counter increments in ISSUE and WAIT.
  - If it reaches TIMEOUT_CYCLES−1 with no csr_rvalid: go to RESP with wb_rsp=3'b111, wb_data=0.
  - csr_rvalid in the same cycle wins over timeout.
- RESP:
  - wb_valid=1, wb_rd_idx=registered rd.
  - wb_we = read & ~wb_rsp[2] & (rd≠0).
  - Outputs hold until wb_ready; then go to IDLE and clear wb_* to 0.
- Throughput: at most one request in flight. Minimum latency with csr_rvalid in ISSUE is accept T → wb_valid T+2. A new request can be accepted the cycle after the wb handshake.
- csr_rvalid outside ISSUE/WAIT is ignored and csr_rrsp stays 0.

Test Plan:
- CSRRW addr 0x3A0, rd=5, rs1=3, rs1_val=0xDEADBEEF; bus returns 0x1234 two cycles after csr_valid → csr_op=11, single csr_valid pulse, csr_rrsp pulse; wb_data=0x1234, wb_we=1, wb_rsp=000.
- CSRRS rs1_idx=0, rd=0 (csrr-to-x0 form), addr 0x3B0 → csr_op=10; wb_we=0 because rd=0.
- CSRRWI rd=0, uimm=0x1F → csr_op=01, csr_imm=0x1F, funct3=101; wb_we=0.
- funct3=100 → no csr_valid; wb_valid next cycle with wb_rsp=110.
- addr 0x7C0 with bus silent, TIMEOUT_CYCLES=16 → wb_rsp=111 exactly 16 cycles after csr_valid; csr_rrsp never asserted.
- PMP exception response csr_reg_rsp=101 with wb_ready held 0 for 4 cycles → wb outputs stable, wb_we=0. Then assert rst during WAIT of a second request → IDLE, all outputs 0 next cycle.
